// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Optional forwarding-aware hazard detection is selected with HAZARD_FWD_EN.
package hazard_ctrl_pkg;

  localparam int          REG_AW       = 5;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam int          STALL_W      = 6;

  // Stall vector bit positions
  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one register read port against every scoreboard slot; one match bit per slot.
// With HAZARD_FWD_EN only a load sitting in slot0 (EX) can produce a match.
module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic                  read_i,
  input  logic [REG_AW-1:0]     addr_i,
  input  slot_t [PIPE_DEPTH-1:0] slots_i,
  output logic [PIPE_DEPTH-1:0] match_o
);

  logic [PIPE_DEPTH-1:0] w_hit;
  logic [PIPE_DEPTH-1:0] w_is_load;
  logic                  w_unused_load;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_hit     = '0;
    w_is_load = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_hit[i]     = read_i && slots_i[i].valid && (slots_i[i].addr == addr_i) &&
                     (addr_i != NOP_REG_ADDR);
      w_is_load[i] = slots_i[i].is_load;
    end
  end

`ifdef HAZARD_FWD_EN
  // MEM/WB results are forwarded; only load-use in EX cannot be covered.
  assign match_o       = {{(PIPE_DEPTH-1){1'b0}}, w_hit[0] & w_is_load[0]};
  assign w_unused_load = ^{w_hit[PIPE_DEPTH-1:1], w_is_load[PIPE_DEPTH-1:1]};
`else
  assign match_o       = w_hit;
  assign w_unused_load = ^w_is_load;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: in-flight write scoreboard, stall vector, flush sequencing
// and saturating hazard-stall counter. HAZARD_FWD_EN restricts stalls to load-use hazards.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_reg1_read_i,
  input  logic [REG_AW-1:0]  id_reg1_addr_i,
  input  logic               id_reg2_read_i,
  input  logic [REG_AW-1:0]  id_reg2_addr_i,
  input  logic               id_wreg_i,
  input  logic [REG_AW-1:0]  id_wd_i,
  input  logic               id_is_load_i,
  input  logic               stallreq_ex_i,
  input  logic               flush_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [CNT_W-1:0]   hazard_cnt_o
);

  localparam int               FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e                r_state;
  logic [FC_W-1:0]       r_flush_cnt;
  slot_t [PIPE_DEPTH-1:0] r_slot;

  slot_t                 w_id_rec;
  logic [PIPE_DEPTH-1:0] w_match1;
  logic [PIPE_DEPTH-1:0] w_match2;
  logic                  w_hazard;
  logic [STALL_W-1:0]    w_stall;

  always_comb begin
    w_id_rec.valid   = id_wreg_i && (id_wd_i != NOP_REG_ADDR);
    w_id_rec.addr    = id_wd_i;
    w_id_rec.is_load = id_is_load_i;
  end

  hazard_cmp #(.PIPE_DEPTH(PIPE_DEPTH)) u_cmp_reg1 (
    .read_i  (id_reg1_read_i),
    .addr_i  (id_reg1_addr_i),
    .slots_i (r_slot),
    .match_o (w_match1)
  );

  hazard_cmp #(.PIPE_DEPTH(PIPE_DEPTH)) u_cmp_reg2 (
    .read_i  (id_reg2_read_i),
    .addr_i  (id_reg2_addr_i),
    .slots_i (r_slot),
    .match_o (w_match2)
  );

  assign w_hazard = |{w_match1, w_match2};

  // A flush request outranks any stall raised in the same cycle.
  always_comb begin
    w_stall = STALL_NONE;
    if (r_state == S_IDLE && !flush_i) begin
      if (stallreq_ex_i) w_stall = STALL_EX;
      else if (w_hazard) w_stall = STALL_ID;
    end
  end

  assign stall_o = w_stall;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours (the slot shift relies on this).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flush_cnt  <= '0;
      flush_o      <= 1'b0;
      hazard_cnt_o <= '0;
      // NOTE: the scoreboard is reset too; a stale valid slot would stall after reset.
      r_slot       <= '0;
    end else begin
      if (w_stall == STALL_ID && hazard_cnt_o != '1)
        hazard_cnt_o <= hazard_cnt_o + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
            flush_o     <= 1'b1;
            r_slot      <= '0;
          end else if (w_stall[ST_EX]) begin
            // EX holds its instruction; a bubble drains into MEM.
            r_slot[1] <= '0;
            for (int i = 2; i < PIPE_DEPTH; i++) r_slot[i] <= r_slot[i-1];
          end else begin
            r_slot[0] <= w_stall[ST_ID] ? slot_t'('0) : w_id_rec;
            for (int i = 1; i < PIPE_DEPTH; i++) r_slot[i] <= r_slot[i-1];
          end
        end
        S_FLUSH: begin
          r_slot <= '0;
          if (flush_i) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt == '0) begin
            r_state <= S_IDLE;
            flush_o <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FWD_EN if defined.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_is_load_i;
  logic [4:0]         id_reg1_addr_i, id_reg2_addr_i, id_wd_i;
  logic               stallreq_ex_i, flush_i;
  logic [5:0]         stall_o;
  logic               flush_o;
  logic [CNT_W-1:0]   hazard_cnt_o;

  int                 checks   = 0;
  int                 failures = 0;
  logic [CNT_W-1:0]   exp_cnt;

  hazard_ctrl #(.PIPE_DEPTH(3), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_wreg_i      (id_wreg_i),
    .id_wd_i        (id_wd_i),
    .id_is_load_i   (id_is_load_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .hazard_cnt_o   (hazard_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                       input logic wreg, input logic [4:0] wd, input logic ld,
                       input logic sreq, input logic fl);
    id_reg1_read_i = r1;   id_reg1_addr_i = a1;
    id_reg2_read_i = r2;   id_reg2_addr_i = a2;
    id_wreg_i      = wreg; id_wd_i        = wd;
    id_is_load_i   = ld;   stallreq_ex_i  = sreq;
    flush_i        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1: checks the combinational stall of this cycle, then advances one edge.
  task automatic cyc(input string tag, input logic [5:0] exp_stall);
    #2;
    check(tag, 32'(stall_o), 32'(exp_stall));
    if (exp_stall == STALL_ID && exp_cnt != CNT_MAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_cnt", 32'(hazard_cnt_o), 32'd0);
    rst = 1'b0;

    // ALU producer r3, consumer on port 1
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    cyc("alu_wr", STALL_NONE);
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("alu_dep0", FWD ? STALL_NONE : STALL_ID);
    cyc("alu_dep1", FWD ? STALL_NONE : STALL_ID);
    cyc("alu_dep2", FWD ? STALL_NONE : STALL_ID);
    cyc("alu_dep3", STALL_NONE);
    check("cnt_alu", 32'(hazard_cnt_o), FWD ? 32'd0 : 32'd3);

    // Load producer r5, consumer on port 2
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("ld_wr", STALL_NONE);
    drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("ld_use0", STALL_ID);
    cyc("ld_use1", FWD ? STALL_NONE : STALL_ID);
    cyc("ld_use2", FWD ? STALL_NONE : STALL_ID);
    cyc("ld_use3", STALL_NONE);
    check("cnt_ld", 32'(hazard_cnt_o), FWD ? 32'd1 : 32'd6);

    // r0 never hazards
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r0_wr", STALL_NONE);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("r0_rd", STALL_NONE);
    idle();
    cyc("r0_drain", STALL_NONE);

    // EX busy for 4 cycles while r9 dependency is pending
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("sx_wr", STALL_NONE);
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("sx_ex", STALL_EX);
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("sx_dep0", FWD ? STALL_NONE : STALL_ID);
    cyc("sx_dep1", FWD ? STALL_NONE : STALL_ID);
    cyc("sx_dep2", FWD ? STALL_NONE : STALL_ID);
    cyc("sx_dep3", STALL_NONE);
    check("cnt_sx", 32'(hazard_cnt_o), FWD ? 32'd1 : 32'd9);

    // Counter saturation: four load-use pairs
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(10 + k), 1'b1, 1'b0, 1'b0);
      cyc("sat_wr", STALL_NONE);
      drive(1'b1, 5'(10 + k), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("sat_use0", STALL_ID);
      cyc("sat_use1", FWD ? STALL_NONE : STALL_ID);
      cyc("sat_use2", FWD ? STALL_NONE : STALL_ID);
      cyc("sat_use3", STALL_NONE);
    end
    check("cnt_sat", 32'(hazard_cnt_o), FWD ? 32'd5 : 32'd15);
    check("cnt_model", 32'(hazard_cnt_o), 32'(exp_cnt));

    // Flush pulse on the hazard cycle
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    cyc("fl_wr", STALL_NONE);
    drive(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("fl_req", STALL_NONE);
    drive(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("fl_active", 32'(flush_o), 32'd1);
    cyc("fl_stall", STALL_NONE);
    #1;
    check("fl_done", 32'(flush_o), 32'd0);
    cyc("fl_after", STALL_NONE);
    check("cnt_fl", 32'(hazard_cnt_o), 32'(exp_cnt));

    // Level flush extends the flush window
    idle();
    flush_i = 1'b1;
    cyc("fx_req", STALL_NONE);
    #1;
    check("fx_hold0", 32'(flush_o), 32'd1);
    cyc("fx_lvl", STALL_NONE);
    flush_i = 1'b0;
    #1;
    check("fx_hold1", 32'(flush_o), 32'd1);
    cyc("fx_rel", STALL_NONE);
    #1;
    check("fx_end", 32'(flush_o), 32'd0);
    cyc("fx_idle", STALL_NONE);

    // Asynchronous reset during a hazard stall
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    cyc("rs_wr", STALL_NONE);
    drive(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rs_pre", 32'(stall_o), 32'(STALL_ID));
    #1;
    rst = 1'b1;
    #1;
    check("rs_stall", 32'(stall_o), 32'd0);
    check("rs_cnt", 32'(hazard_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    cyc("rs_after", STALL_NONE);
    check("rs_cnt_after", 32'(hazard_cnt_o), 32'd0);

    // Asynchronous reset during a flush
    idle();
    flush_i = 1'b1;
    cyc("rf_req", STALL_NONE);
    #1;
    check("rf_active", 32'(flush_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rf_cleared", 32'(flush_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    cyc("rf_idle", STALL_NONE);
    #1;
    check("rf_flush_low", 32'(flush_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
